fdiv_seq_ctrl: RTL and testbench
================================

# fdiv_seq_ctrl

Sequencer that owns the programmable divider `fDiv`: it holds a small table of {divide ratio, duration} entries and plays them in order, driving the divider's `DivN` and `reset` inputs so the divider's output steps through a programmed tone or rate sequence. It sits between the board control logic (start/stop, table writes) and one `fDiv` instance. Entry durations are measured in pulses of an external `tick` timebase.

## Interface
- `DEPTH`, 8: number of table entries (power of two, 2..16)
- `AW`, 3: address width, log2(DEPTH)
- `DUR_W`, 16: duration field width in ticks

- `fin`  in  1  system clock; all logic on posedge
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  table write strobe, one entry per cycle
- `wr_addr`  in  AW  table entry to write
- `wr_div`  in  32  divide ratio for the entry; goes to `fDiv` `DivN`
- `wr_dur`  in  DUR_W  entry duration in ticks; 0 means skip the entry
- `seq_len`  in  AW+1  number of entries to play, starting at entry 0; values above DEPTH clamp to DEPTH
- `start`  in  1  one-cycle request to begin playback
- `stop`  in  1  one-cycle abort request
- `tick`  in  1  timebase pulse, one `fin` cycle wide
- `div_n`  out  32  divide ratio to `fDiv` `DivN`
- `div_reset`  out  1  active-high reset to `fDiv`
- `busy`  out  1  high from LOAD of the first entry until return to IDLE
- `done`  out  1  one-cycle pulse when a sequence completes normally
- `cur_idx`  out  AW  index of the entry being loaded or played

## Operation
- States: IDLE, LOAD, PLAY, NEXT. `div_reset` is decoded from the state register: it is 0 only in PLAY. `busy` is 1 in LOAD, PLAY and NEXT.
- Reset values: state IDLE, `div_n`=0, `div_reset`=1, `busy`=0, `done`=0, `cur_idx`=0, duration counter 0. The table is not reset.
- Table writes are accepted in every state. A write to the entry currently playing takes effect the next time that entry is loaded.
- IDLE:
  - `start` with clamped `seq_len`≠0 → LOAD, `cur_idx`=0.
  - `start` with `seq_len`=0 → stay in IDLE and pulse `done` on the next cycle.
- LOAD, one cycle:
  - Load `div_n` and the duration counter from entry `cur_idx`.
  - Go to PLAY if duration≠0; go to NEXT if duration=0. In the skip case `div_n` is still updated.
- PLAY:
  - Each `tick` decrements the duration counter.
  - A `tick` seen while the counter equals 1 → NEXT.
- NEXT, one cycle:
  - If `cur_idx`=len−1 → IDLE, `done`=1 for one cycle, `div_n` cleared to 0.
  - Otherwise `cur_idx`+1 → LOAD.
- `tick` in IDLE, LOAD or NEXT is ignored and is not queued.
- `stop` in any state → IDLE on the next edge, with `div_n`=0, `cur_idx`=0 and no `done` pulse. When `stop` and `start` arrive in the same cycle, `stop` wins.
- `start` while `busy` is ignored. `seq_len` is sampled continuously, so the bench holds it stable while `busy`.

## Timing
- Edge N samples `start` → state LOAD, `busy`=1, `div_reset`=1.
- Edge N+1 → `div_n` valid, PLAY, `div_reset`=0. The divider first counts at edge N+2.
- The D-th `tick` sampled in PLAY at edge M → NEXT. Edge M+1 → LOAD (`div_reset`=1) or IDLE.
- Gap between consecutive entries: exactly 2 cycles with `div_reset` high (NEXT, LOAD). This restarts divider phase at each entry.
- `done` is registered and asserts in the same cycle the state first reads IDLE.
- Asynchronous reset mid-sequence forces all reset values immediately. The divider is held in reset from that point.

## Configuration
- `FDIV_SEQ_LOOP_EN`
  - Defined: NEXT at the last entry goes to LOAD with `cur_idx`=0, so the sequence repeats until `stop`. `done` never pulses, except for `start` with `seq_len`=0.
  - Undefined: one-shot playback as described above.

## Test plan
- Write entry 0={1000,3} and entry 1={500,2}, set `seq_len`=2, pulse `start`, tick every 10 cycles → `div_n`=1000 for 3 ticks, a 2-cycle `div_reset` gap, `div_n`=500 for 2 ticks, one `done` pulse, then `div_n`=0 and `busy`=0.
- Set entry 1 duration=0 with 3 entries → entry 1 is in LOAD for one cycle then NEXT. `div_reset` never drops for entry 1, and entry 2 plays normally.
- Pulse `stop` during PLAY of entry 1 → next edge IDLE, `div_n`=0, `div_reset`=1, no `done`. Pulse `start` and `stop` together in IDLE → remains IDLE.
- Pulse `start` with `seq_len`=0 → `done` pulses once, `busy` stays 0. Set `seq_len`=15 with DEPTH=8 → all 8 entries play.
- Assert reset low mid-PLAY → all outputs at reset values asynchronously. Release and replay → correct sequence.
- With `FDIV_SEQ_LOOP_EN` defined and 2 entries → entries alternate 0,1,0,1 with no `done`. `stop` terminates the loop.

Source files
------------

// File: rtl/fdiv_seq_ctrl.sv
// rtl/fdiv_seq_ctrl.sv - plays a {divide ratio, duration} table into one fDiv instance
// Define FDIV_SEQ_LOOP_EN to repeat the sequence until stop instead of one-shot playback.
module fdiv_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DUR_W = 16
) (
  input  logic             fin,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [31:0]      wr_div,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW:0]      seq_len,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  output logic [31:0]      div_n,
  output logic             div_reset,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, NEXT} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t           state;
  logic [DUR_W-1:0] dur_cnt;
  logic [31:0]      tab_div [DEPTH];
  logic [DUR_W-1:0] tab_dur [DEPTH];
  logic [AW:0]      len_c;
  logic             last_idx;

  assign len_c     = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
  assign last_idx  = (({1'b0, cur_idx} + (AW+1)'(1)) >= len_c);
  assign div_reset = (state != PLAY);
  assign busy      = (state != IDLE);

  // Table has no reset; contents survive a controller reset.
  always_ff @(posedge fin) begin
    if (wr_en) begin
      tab_div[wr_addr] <= wr_div;
      tab_dur[wr_addr] <= wr_dur;
    end
  end

  always_ff @(posedge fin or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      div_n   <= '0;
      done    <= 1'b0;
      cur_idx <= '0;
      dur_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        div_n   <= '0;
        cur_idx <= '0;
        dur_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (len_c != '0) begin
                state   <= LOAD;
                cur_idx <= '0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          LOAD: begin
            div_n   <= tab_div[cur_idx];
            dur_cnt <= tab_dur[cur_idx];
            state   <= (tab_dur[cur_idx] != '0) ? PLAY : NEXT;
          end
          PLAY: begin
            if (tick) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
              if (dur_cnt == DUR_W'(1)) state <= NEXT;
            end
          end
          NEXT: begin
            if (last_idx) begin
`ifdef FDIV_SEQ_LOOP_EN
              state   <= LOAD;
              cur_idx <= '0;
`else
              state   <= IDLE;
              done    <= 1'b1;
              div_n   <= '0;
              cur_idx <= '0;
`endif
            end else begin
              state   <= LOAD;
              cur_idx <= cur_idx + AW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// tb/tb_fdiv_seq_ctrl.sv - self-checking bench for fdiv_seq_ctrl with a table-level playback model
module tb_fdiv_seq_ctrl;

  logic        fin, reset, wr_en, start, stop, tick;
  logic [2:0]  wr_addr;
  logic [31:0] wr_div;
  logic [15:0] wr_dur;
  logic [3:0]  seq_len;
  logic [31:0] div_n;
  logic        div_reset, busy, done;
  logic [2:0]  cur_idx;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_div [8];
  logic [15:0] m_dur [8];

  fdiv_seq_ctrl #(.DEPTH(8), .AW(3), .DUR_W(16)) dut (
    .fin(fin), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_div(wr_div),
    .wr_dur(wr_dur), .seq_len(seq_len), .start(start), .stop(stop), .tick(tick),
    .div_n(div_n), .div_reset(div_reset), .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  initial fin = 1'b0;
  always #5 fin = ~fin;

  task automatic wr(input int a, input logic [31:0] d, input logic [15:0] t);
    @(negedge fin);
    wr_en = 1'b1; wr_addr = a[2:0]; wr_div = d; wr_dur = t;
    @(negedge fin);
    wr_en = 1'b0;
    m_div[a] = d;
    m_dur[a] = t;
  endtask

  task automatic test_reset();
    @(negedge fin);
    checks++;
    if (div_n !== 32'd0 || div_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_values div_n=%0d div_reset=%b busy=%b done=%b cur_idx=%0d want 0/1/0/0/0",
               div_n, div_reset, busy, done, cur_idx);
    end
    reset = 1'b1;
    @(negedge fin);
    checks++;
    if (busy !== 1'b0 || div_reset !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b div_reset=%b done=%b want 0/1/0", busy, div_reset, done);
    end
  endtask

  // Expected playback: every entry below the clamped length with nonzero duration
  // plays for exactly its duration in ticks; each skipped entry adds 2 reset cycles.
  task automatic run_seq(input string name, input int len);
    logic [31:0] exp_div [$];
    int          exp_dur [$];
    int          exp_gap [$];
    int          n, skips, seg, cnt, gap, cyc;
    logic        in_play, ended;
    logic [31:0] seg_div;
    n = (len > 8) ? 8 : len;
    skips = 0;
    for (int i = 0; i < n; i++) begin
      if (m_dur[i] == 16'd0) skips++;
      else begin
        exp_gap.push_back((exp_div.size() == 0) ? 1 + 2 * skips : 2 + 2 * skips);
        exp_div.push_back(m_div[i]);
        exp_dur.push_back(int'(m_dur[i]));
        skips = 0;
      end
    end
    seq_len = len[3:0];
    @(negedge fin);
    start = 1'b1;
    seg = 0; cnt = 0; gap = 0; in_play = 1'b0; ended = 1'b0; seg_div = '0;
    for (cyc = 0; cyc < 4000 && !ended; cyc++) begin
      @(negedge fin);
      start = 1'b0;
      if (!busy) begin
        ended = 1'b1;
        checks++;
        if (done !== 1'b1 || div_n !== 32'd0 || div_reset !== 1'b1) begin
          failures++;
          $display("FAIL %s end done=%b div_n=%0d div_reset=%b want 1/0/1", name, done, div_n, div_reset);
        end
        checks++;
        if (seg != exp_div.size()) begin
          failures++;
          $display("FAIL %s seg_count got %0d want %0d", name, seg, exp_div.size());
        end
      end else if (div_reset) begin
        if (in_play) begin
          checks++;
          if (cnt != exp_dur[seg-1]) begin
            failures++;
            $display("FAIL %s seg%0d ticks got %0d want %0d", name, seg - 1, cnt, exp_dur[seg-1]);
          end
          in_play = 1'b0;
          gap = 0;
        end
        gap++;
      end else if (!in_play) begin
        checks++;
        if (seg >= exp_div.size()) begin
          failures++;
          $display("FAIL %s extra_seg div_n=%0d want no segment %0d", name, div_n, seg);
        end else if (div_n !== exp_div[seg] || gap != exp_gap[seg]) begin
          failures++;
          $display("FAIL %s seg%0d div_n=%0d gap=%0d want %0d gap %0d", name, seg, div_n, gap,
                   exp_div[seg], exp_gap[seg]);
        end
        in_play = 1'b1; seg_div = div_n; cnt = 0; seg++;
      end else begin
        checks++;
        if (div_n !== seg_div) begin
          failures++;
          $display("FAIL %s div_stable got %0d want %0d", name, div_n, seg_div);
        end
      end
      tick = ($urandom_range(0, 2) == 0);
      if (busy && !div_reset && tick) cnt++;
    end
    tick = 1'b0;
    checks++;
    if (!ended) begin
      failures++;
      $display("FAIL %s timeout busy=%b want 0", name, busy);
    end else begin
      @(negedge fin);
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL %s done_width done=%b want 0", name, done);
      end
    end
  endtask

  task automatic test_basic();
    wr(0, 32'd1000, 16'd3);
    wr(1, 32'd500, 16'd2);
    run_seq("basic", 2);
  endtask

  task automatic test_skip();
    wr(0, 32'd77, 16'd2);
    wr(1, 32'd88, 16'd0);
    wr(2, 32'd99, 16'd3);
    run_seq("skip", 3);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 8; a++) wr(a, $urandom, 16'($urandom_range(0, 4)));
      run_seq("random", (it == 5) ? 15 : int'($urandom_range(1, 8)));
    end
  endtask

  task automatic test_zero_len();
    seq_len = 4'd0;
    @(negedge fin);
    start = 1'b1;
    @(negedge fin);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_len done=%b busy=%b want 1/0", done, busy);
    end
    @(negedge fin);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_after done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_stop();
    logic hit;
    wr(0, 32'd111, 16'd3);
    wr(1, 32'd222, 16'd40);
    seq_len = 4'd2;
    @(negedge fin);
    start = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
      @(negedge fin);
      start = 1'b0;
      if (cur_idx == 3'd1 && !div_reset) hit = 1'b1;
      else tick = $urandom_range(0, 1);
    end
    tick = 1'b0;
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL stop_reach_play cur_idx=%0d div_reset=%b want 1/0", cur_idx, div_reset);
    end
    stop = 1'b1;
    @(negedge fin);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || div_n !== 32'd0 || div_reset !== 1'b1 || cur_idx !== 3'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL stop_state busy=%b div_n=%0d div_reset=%b cur_idx=%0d done=%b want 0/0/1/0/0",
               busy, div_n, div_reset, cur_idx, done);
    end
    for (int c = 0; c < 10; c++) begin
      tick = $urandom_range(0, 1);
      @(negedge fin);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL stop_quiet done=%b busy=%b want 0/0", done, busy);
      end
    end
    tick = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    @(negedge fin);
    start = 1'b0;
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL start_stop busy=%b done=%b want 0/0", busy, done);
      end
      @(negedge fin);
    end
  endtask

  task automatic test_async_reset();
    logic hit;
    wr(0, 32'd1000, 16'd3);
    wr(1, 32'd500, 16'd2);
    seq_len = 4'd2;
    @(negedge fin);
    start = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
      @(negedge fin);
      start = 1'b0;
      if (!div_reset) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL areset_reach_play div_reset=%b want 0", div_reset);
    end
    @(posedge fin);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (div_n !== 32'd0 || div_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cur_idx !== 3'd0) begin
      failures++;
      $display("FAIL areset_values div_n=%0d div_reset=%b busy=%b done=%b cur_idx=%0d want 0/1/0/0/0",
               div_n, div_reset, busy, done, cur_idx);
    end
    @(negedge fin);
    reset = 1'b1;
    run_seq("replay", 2);
  endtask

`ifdef FDIV_SEQ_LOOP_EN
  task automatic test_loop();
    int   seg, cnt;
    logic in_play;
    wr(0, 32'd321, 16'd2);
    wr(1, 32'd654, 16'd3);
    seq_len = 4'd2;
    @(negedge fin);
    start = 1'b1;
    seg = 0; cnt = 0; in_play = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge fin);
      start = 1'b0;
      if (done !== 1'b0 || busy !== 1'b1) begin
        checks++; failures++;
        $display("FAIL loop_busy done=%b busy=%b want 0/1", done, busy);
      end
      if (div_reset && in_play) begin
        checks++;
        if (cnt != int'(m_dur[(seg-1)%2])) begin
          failures++;
          $display("FAIL loop_ticks seg%0d got %0d want %0d", seg - 1, cnt, m_dur[(seg-1)%2]);
        end
        in_play = 1'b0;
      end else if (!div_reset && !in_play) begin
        checks++;
        if (div_n !== m_div[seg%2]) begin
          failures++;
          $display("FAIL loop_div seg%0d got %0d want %0d", seg, div_n, m_div[seg%2]);
        end
        in_play = 1'b1; cnt = 0; seg++;
      end
      tick = ($urandom_range(0, 2) == 0);
      if (!div_reset && tick) cnt++;
    end
    tick = 1'b0;
    checks++;
    if (seg < 4) begin
      failures++;
      $display("FAIL loop_count got %0d want at least 4", seg);
    end
    stop = 1'b1;
    @(negedge fin);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || div_n !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL loop_stop busy=%b div_n=%0d done=%b want 0/0/0", busy, div_n, done);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_div = '0; wr_dur = '0;
    seq_len = '0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    repeat (3) @(negedge fin);
    test_reset();
    test_zero_len();
    test_stop();
`ifdef FDIV_SEQ_LOOP_EN
    test_loop();
`else
    test_basic();
    test_skip();
    test_random();
    test_async_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
